// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave timer keypad-entry stage.
// State encodings are fixed so other blocks and benches can decode them.
package timer_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t mins;
    bcd_t tens;
    bcd_t ones;
  } bcd_time_t;

  localparam bcd_t DIGIT_MAX_DEF = 4'd9;
  localparam bcd_t MAX_TENS_DEF  = 4'd5;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ENTRY = 2'b01;
  localparam logic [1:0] ST_LOAD  = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b11;

  function automatic logic is_zero_time(input bcd_time_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/bcd_shift_buffer.sv
// Three-digit BCD entry buffer: new digits enter at the ones position and
// push older digits toward minutes; the oldest minutes digit falls off.
module bcd_shift_buffer
  import timer_pkg::*;
(
  input  logic      clk,
  input  logic      clearn,
  input  logic      clr,
  input  logic      shift,
  input  bcd_t      din,
  output bcd_time_t q
);

  // Clear wins over shift so a cancel can never leave a stray digit behind.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      q.mins <= q.tens;
      q.tens <= q.ones;
      q.ones <= din;
    end
  end

endmodule

// File: rtl/timer_digit_loader.sv
// Keypad entry, validation and load/enable sequencing for the BCD
// down-counter cascade of the microwave timer.
module timer_digit_loader
  import timer_pkg::*;
#(
  parameter bcd_t MAX_TENS  = MAX_TENS_DEF,
  parameter bcd_t DIGIT_MAX = DIGIT_MAX_DEF
)
(
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic       start,
  input  logic       cancel,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       loadn,
  output logic [3:0] data_mins,
  output logic [3:0] data_tens,
  output logic [3:0] data_ones,
  output logic       en,
  output logic       entry_err,
  output logic       done
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       buf_clr;
  logic       buf_shift;
  logic       loadn_nxt;
  logic       en_nxt;
  logic       err_nxt;
  logic       done_nxt;
  logic       key_ok;
  logic       key_bad;
  bcd_time_t  buf_q;

  assign key_ok  = key_valid && (key_data <= DIGIT_MAX);
  assign key_bad = key_valid && (key_data >  DIGIT_MAX);

  bcd_shift_buffer u_buf (
    .clk    (clk),
    .clearn (clearn),
    .clr    (buf_clr),
    .shift  (buf_shift),
    .din    (key_data),
    .q      (buf_q)
  );

  assign data_mins = buf_q.mins;
  assign data_tens = buf_q.tens;
  assign data_ones = buf_q.ones;

  // Priority is cancel > start > key; a start that is accepted or rejected
  // swallows any key arriving alongside it.
  always_comb begin
    state_nxt = state;
    buf_clr   = 1'b0;
    buf_shift = 1'b0;
    loadn_nxt = 1'b1;
    en_nxt    = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_ok) begin
          buf_shift = 1'b1;
          state_nxt = ST_ENTRY;
        end else if (key_bad) begin
          err_nxt = 1'b1;
        end
      end
      ST_ENTRY: begin
        if (cancel) begin
          buf_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (start && is_zero_time(buf_q)) begin
          err_nxt = 1'b1;
        end else if (start && (buf_q.tens > MAX_TENS)) begin
          err_nxt = 1'b1;
        end else if (start && door_closed) begin
          loadn_nxt = 1'b0;
          state_nxt = ST_LOAD;
        end else if (key_ok) begin
          buf_shift = 1'b1;
        end else if (key_bad) begin
          err_nxt = 1'b1;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cancel) begin
          buf_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (timer_zero && en) begin
          done_nxt  = 1'b1;
          buf_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          en_nxt = door_closed;
        end
      end
      default: begin
        buf_clr   = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state     <= ST_IDLE;
      loadn     <= 1'b1;
      en        <= 1'b0;
      entry_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      loadn     <= loadn_nxt;
      en        <= en_nxt;
      entry_err <= err_nxt;
      done      <= done_nxt;
    end
  end

endmodule
